// File: rtl/main_run_pkg.sv
// Shared types and channel geometry for the main accelerator run controller.
package main_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WR,
        S_START,
        S_RUN,
        S_RD,
        S_OUT,
        S_FIN
    } state_t;

    localparam int ACC_WORD_BITS = 32;
    localparam int NUM_CH        = 2;
    localparam int CH_ADDR_BITS  = 10;
    localparam int CH_DATA_BITS  = 64;
    localparam int CH_SIZE_BITS  = 7;

    // Byte address of word idx; wraps in the 10-bit channel address space.
    function automatic logic [CH_ADDR_BITS-1:0] word_addr(
        input logic [CH_ADDR_BITS-1:0] base,
        input logic [7:0]              idx
    );
        return base + {idx, 2'b00};
    endfunction

endpackage

// File: rtl/main_run_ctrl_if.sv
// Streams, accelerator control and slave memory port of the run controller.
interface main_run_ctrl_if;
    import main_run_pkg::*;

    logic                             in_valid;
    logic [ACC_WORD_BITS-1:0]         in_data;
    logic                             in_ready;
    logic                             out_valid;
    logic [ACC_WORD_BITS-1:0]         out_data;
    logic                             out_ready;
    logic                             acc_start_port;
    logic                             acc_done_port;
    logic [NUM_CH-1:0]                S_oe_ram;
    logic [NUM_CH-1:0]                S_we_ram;
    logic [NUM_CH*CH_ADDR_BITS-1:0]   S_addr_ram;
    logic [NUM_CH*CH_DATA_BITS-1:0]   S_Wdata_ram;
    logic [NUM_CH*CH_SIZE_BITS-1:0]   S_data_ram_size;
    logic [NUM_CH*CH_DATA_BITS-1:0]   Sout_Rdata_ram;
    logic [NUM_CH-1:0]                Sout_DataRdy;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output acc_start_port,
        input  acc_done_port,
        output S_oe_ram, S_we_ram, S_addr_ram,
        output S_Wdata_ram, S_data_ram_size,
        input  Sout_Rdata_ram, Sout_DataRdy
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  acc_start_port,
        output acc_done_port,
        input  S_oe_ram, S_we_ram, S_addr_ram,
        input  S_Wdata_ram, S_data_ram_size,
        output Sout_Rdata_ram, Sout_DataRdy
    );

endinterface

// File: rtl/main_run_ctrl_slave_port_access.sv
// Single-channel slave access: holds a read or write request until DataRdy.
module slave_port_access
    import main_run_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     wr,
    input  logic [CH_ADDR_BITS-1:0]  addr,
    input  logic [ACC_WORD_BITS-1:0] wdata,
    input  logic                     data_rdy,
    output logic                     done,
    output logic                     oe,
    output logic                     we,
    output logic [CH_ADDR_BITS-1:0]  ch_addr,
    output logic [CH_DATA_BITS-1:0]  ch_wdata,
    output logic [CH_SIZE_BITS-1:0]  ch_size
);

    assign done = (oe | we) & data_rdy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oe       <= 1'b0;
            we       <= 1'b0;
            ch_addr  <= '0;
            ch_wdata <= '0;
            ch_size  <= '0;
        end else begin
            unique case (1'b1)
                req: begin
                    oe       <= ~wr;
                    we       <= wr;
                    ch_addr  <= addr;
                    ch_wdata <= wr ? CH_DATA_BITS'(wdata) : '0;
                    ch_size  <= CH_SIZE_BITS'(ACC_WORD_BITS);
                end
                done: begin
                    oe       <= 1'b0;
                    we       <= 1'b0;
                    ch_addr  <= '0;
                    ch_wdata <= '0;
                    ch_size  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/main_run_ctrl.sv
// Load / start / wait-for-done / read-back sequencer for the HLS main accelerator.
module main_run_ctrl
    import main_run_pkg::*;
#(
    parameter int BASE_ADDR  = 256,
    parameter int LOAD_WORDS = 100,
    parameter int READ_WORDS = 100,
    parameter int TIMEOUT    = 200000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    output logic                busy,
    output logic                run_done,
    output logic                timeout,
    output logic [31:0]         cycles,
    main_run_ctrl_if.master     io
);

    localparam int MAX_WORDS =
        (LOAD_WORDS > READ_WORDS) ? LOAD_WORDS : READ_WORDS;
    localparam logic [CH_ADDR_BITS-1:0] BASE =
        CH_ADDR_BITS'(BASE_ADDR);
    localparam logic [9:0]  LAST_LD = 10'(LOAD_WORDS - 1);
    localparam logic [9:0]  LAST_RD = 10'(READ_WORDS - 1);
    localparam logic [31:0] LIMIT   = 32'(TIMEOUT);

    if (LOAD_WORDS < 1 || LOAD_WORDS > 1023 ||
        READ_WORDS < 1 || READ_WORDS > 1023 ||
        BASE_ADDR + 4 * (MAX_WORDS - 1) >= 1024) begin : g_bad_cfg
        $error("main_run_ctrl: array window outside slave address space");
    end

    state_t                    state;
    state_t                    state_n;
    logic [9:0]                idx;
    logic [9:0]                req_idx;
    logic [31:0]               cnt;
    logic                      req;
    logic                      req_wr;
    logic                      xfer_done;
    logic                      start_q;
    logic                      out_valid_q;
    logic [ACC_WORD_BITS-1:0]  out_data_q;
    logic                      oe0;
    logic                      we0;
    logic [CH_ADDR_BITS-1:0]   ch_addr;
    logic [CH_DATA_BITS-1:0]   ch_wdata;
    logic [CH_SIZE_BITS-1:0]   ch_size;
    logic                      unused_hi;

    slave_port_access u_port (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .wr       (req_wr),
        .addr     (word_addr(BASE, req_idx[7:0])),
        .wdata    (io.in_data),
        .data_rdy (io.Sout_DataRdy[0]),
        .done     (xfer_done),
        .oe       (oe0),
        .we       (we0),
        .ch_addr  (ch_addr),
        .ch_wdata (ch_wdata),
        .ch_size  (ch_size)
    );

    always_comb begin
        state_n = state;
        req     = 1'b0;
        req_wr  = 1'b0;
        req_idx = idx;
        unique case (state)
            S_IDLE:  if (go) state_n = S_LOAD;
            S_LOAD: begin
                if (io.in_valid) begin
                    state_n = S_WR;
                    req     = 1'b1;
                    req_wr  = 1'b1;
                end
            end
            S_WR: begin
                if (xfer_done)
                    state_n = (idx == LAST_LD) ? S_START : S_LOAD;
            end
            S_START: state_n = S_RUN;
            S_RUN: begin
                if (io.acc_done_port) begin
                    state_n = S_RD;
                    req     = 1'b1;
                end else if (cnt == LIMIT) begin
                    state_n = S_FIN;
                end
            end
            S_RD:    if (xfer_done) state_n = S_OUT;
            S_OUT: begin
                req_idx = idx + 10'd1;
                if (io.out_ready) begin
                    if (idx == LAST_RD) begin
                        state_n = S_FIN;
                    end else begin
                        state_n = S_RD;
                        req     = 1'b1;
                    end
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            cycles      <= '0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state    <= state_n;
            busy     <= (state_n != S_IDLE);
            run_done <= (state_n == S_FIN);
            start_q  <= (state_n == S_START);
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        idx     <= '0;
                        timeout <= 1'b0;
                    end
                end
                S_WR: begin
                    if (xfer_done) begin
                        idx <= (idx == LAST_LD) ? '0 : idx + 10'd1;
                        if (idx == LAST_LD) cnt <= 32'd1;
                    end
                end
                S_START: cnt <= cnt + 32'd1;
                // A done on the limit cycle still counts as a normal finish.
                S_RUN: begin
                    if (io.acc_done_port) begin
                        cycles <= cnt;
                    end else if (cnt == LIMIT) begin
                        cycles  <= LIMIT;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_RD: begin
                    if (xfer_done) begin
                        out_data_q  <= io.Sout_Rdata_ram[ACC_WORD_BITS-1:0];
                        out_valid_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        idx         <= req_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready        = (state == S_LOAD);
    assign io.out_valid       = out_valid_q;
    assign io.out_data        = out_data_q;
    assign io.acc_start_port  = start_q;
    assign io.S_oe_ram        = {1'b0, oe0};
    assign io.S_we_ram        = {1'b0, we0};
    assign io.S_addr_ram      = {{CH_ADDR_BITS{1'b0}}, ch_addr};
    assign io.S_Wdata_ram     = {{CH_DATA_BITS{1'b0}}, ch_wdata};
    assign io.S_data_ram_size = {{CH_SIZE_BITS{1'b0}}, ch_size};

    assign unused_hi = ^{io.Sout_Rdata_ram[2*CH_DATA_BITS-1:ACC_WORD_BITS],
                         io.Sout_DataRdy[1]};

endmodule

// File: tb/tb_main_run_ctrl.sv
// Directed bench: slave memory + sorting accelerator model around main_run_ctrl.
module tb_main_run_ctrl;
    import main_run_pkg::*;

    localparam int LW   = 100;
    localparam int RW   = 100;
    localparam int TO   = 1000;
    localparam int BASE = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        go    = 1'b0;
    logic        busy;
    logic        run_done;
    logic        timeout;
    logic [31:0] cycles;

    main_run_ctrl_if io();

    main_run_ctrl #(
        .BASE_ADDR  (BASE),
        .LOAD_WORDS (LW),
        .READ_WORDS (RW),
        .TIMEOUT    (TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .go       (go),
        .busy     (busy),
        .run_done (run_done),
        .timeout  (timeout),
        .cycles   (cycles),
        .io       (io.master)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [31:0] mem [0:255];
    logic [31:0] tmp;
    logic        rdy;
    logic [127:0] rdata;
    int          acc_cnt;
    int          acc_dly    = 0;
    logic        force_done = 1'b0;
    int          rd_cnt     = 0;
    int          bad_bus    = 0;
    int          start_cnt  = 0;
    int          fin_cnt    = 0;
    logic [9:0]  wa_q [$];
    logic [31:0] wd_q [$];

    assign io.Sout_DataRdy   = {1'b0, rdy};
    assign io.Sout_Rdata_ram = rdata;
    assign io.acc_done_port  = (acc_cnt == 1) || force_done;

    // Write latency 1; on start the accelerator sorts the array in place.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdy     <= 1'b0;
            rdata   <= '0;
            acc_cnt <= 0;
        end else begin
            rdy <= (io.S_we_ram[0] | io.S_oe_ram[0]) & ~rdy;
            if ((io.S_we_ram[0] | io.S_oe_ram[0]) &&
                (io.S_data_ram_size != 14'd32 ||
                 io.S_addr_ram[19:10] != 10'd0 ||
                 io.S_Wdata_ram[127:32] != 96'd0 ||
                 io.S_oe_ram[1] || io.S_we_ram[1]))
                bad_bus++;
            if (io.S_oe_ram[0] & ~rdy)
                rdata <= {96'd0, mem[io.S_addr_ram[9:2]]};
            if (io.S_oe_ram[0] & rdy)
                rd_cnt++;
            if (io.S_we_ram[0] & rdy) begin
                mem[io.S_addr_ram[9:2]] = io.S_Wdata_ram[31:0];
                wa_q.push_back(io.S_addr_ram[9:0]);
                wd_q.push_back(io.S_Wdata_ram[31:0]);
            end
            if (io.acc_start_port) begin
                acc_cnt <= acc_dly;
                for (int a = 0; a < LW - 1; a++)
                    for (int b = 64; b < 64 + LW - 1 - a; b++)
                        if (mem[b] > mem[b+1]) begin
                            tmp      = mem[b];
                            mem[b]   = mem[b+1];
                            mem[b+1] = tmp;
                        end
            end else if (acc_cnt != 0) begin
                acc_cnt <= acc_cnt - 1;
            end
        end
    end

    always @(negedge clock) begin
        if (io.acc_start_port) start_cnt++;
        if (run_done) fin_cnt++;
    end

    task automatic load_phase(input bit stall);
        int guard;
        @(negedge clock);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        check("go_busy", {31'd0, busy}, 1);
        check("go_in_ready", {31'd0, io.in_ready}, 1);
        for (int i = 0; i < LW; i++) begin
            if (stall && i == 50) begin
                repeat (3) @(negedge clock);
                go         = 1'b1;
                force_done = 1'b1;
                @(negedge clock);
                go         = 1'b0;
                force_done = 1'b0;
            end
            io.in_valid = 1'b1;
            io.in_data  = 32'((i * 37) % 100);
            guard = 0;
            while (!io.in_ready && guard < 200) begin
                @(negedge clock);
                guard++;
            end
            if (guard >= 200) check("in_ready_wait", 0, 1);
            @(negedge clock);
            io.in_valid = 1'b0;
        end
    endtask

    task automatic read_phase(input bit rnd, output int n_out);
        int          guard;
        bit          hold;
        bit          fin;
        logic [31:0] held;
        n_out = 0;
        hold  = 0;
        fin   = 0;
        held  = '0;
        guard = 0;
        while (!fin && guard < 20000) begin
            @(negedge clock);
            guard++;
            if (hold) begin
                check("hold_valid", {31'd0, io.out_valid}, 1);
                check("hold_data", io.out_data, held);
            end
            if (run_done) fin = 1;
            io.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = io.out_valid && !io.out_ready;
            held = io.out_data;
            if (io.out_valid && io.out_ready) begin
                check("out_data", io.out_data, 32'(n_out));
                n_out++;
            end
        end
        io.out_ready = 1'b0;
        if (!fin) check("run_done_wait", 0, 1);
    endtask

    task automatic run_seq(input bit stall, input bit rnd,
                           input int dly, input bit to_exp,
                           input logic [31:0] exp_cyc);
        int w0, s0, f0, r0, n_out;
        w0      = wa_q.size();
        s0      = start_cnt;
        f0      = fin_cnt;
        r0      = rd_cnt;
        acc_dly = dly;
        load_phase(stall);
        read_phase(rnd, n_out);
        @(negedge clock);
        check("n_writes", 32'(wa_q.size() - w0), LW);
        for (int i = 0; i < LW && w0 + i < wa_q.size(); i++) begin
            check("wr_addr", 32'(wa_q[w0+i]), 32'(BASE + 4 * i));
            check("wr_data", wd_q[w0+i], 32'((i * 37) % 100));
        end
        check("starts", 32'(start_cnt - s0), 1);
        check("run_done", 32'(fin_cnt - f0), 1);
        check("cycles", cycles, exp_cyc);
        check("timeout", {31'd0, timeout}, {31'd0, to_exp});
        check("n_out", 32'(n_out), to_exp ? 32'd0 : 32'(RW));
        check("n_reads", 32'(rd_cnt - r0), to_exp ? 32'd0 : 32'(RW));
        check("busy_end", {31'd0, busy}, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_in_ready"}, {31'd0, io.in_ready}, 0);
        check({tag, "_out_valid"}, {31'd0, io.out_valid}, 0);
        check({tag, "_start"}, {31'd0, io.acc_start_port}, 0);
        check({tag, "_run_done"}, {31'd0, run_done}, 0);
        check({tag, "_oe_we"}, {28'd0, io.S_oe_ram, io.S_we_ram}, 0);
        check({tag, "_addr"}, {12'd0, io.S_addr_ram}, 0);
        check({tag, "_cycles"}, cycles, 0);
        check({tag, "_timeout"}, {31'd0, timeout}, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int guard;
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_quiet("reset");
        reset = 1'b1;
        @(negedge clock);

        run_seq(0, 0, 50, 0, 32'd51);
        run_seq(1, 1, 50, 0, 32'd51);
        run_seq(0, 0, 0, 1, 32'(TO));
        run_seq(0, 1, 1, 0, 32'd2);
        check("bus_fields", 32'(bad_bus), 0);

        acc_dly = 5;
        load_phase(0);
        guard = 0;
        while (!io.S_oe_ram[0] && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        check("rd_reached", {31'd0, io.S_oe_ram[0]}, 1);
        reset = 1'b0;
        @(negedge clock);
        check_quiet("mid_rst");
        reset = 1'b1;
        @(negedge clock);
        run_seq(0, 0, 5, 0, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
